// File: rtl/din_burst_arbiter_if.sv
// Bundle of the arbiter's requester-side and packer-side signals.
// The master modport is the arbiter; the slave modport is its environment.
interface din_burst_arbiter_if;
  logic       arb_en;
  logic       req0;
  logic       req1;
  logic [1:0] din0;
  logic [1:0] din1;
  logic       gnt0;
  logic       gnt1;
  logic [1:0] dout;
  logic       dout_en;
  logic       dout_src;
  logic       busy;

  modport master (
    input  arb_en, req0, req1, din0, din1,
    output gnt0, gnt1, dout, dout_en, dout_src, busy
  );

  modport slave (
    output arb_en, req0, req1, din0, din1,
    input  gnt0, gnt1, dout, dout_en, dout_src, busy
  );
endinterface

// File: rtl/din_burst_arbiter.sv
// Two-requester round-robin arbiter feeding a 2-bit to 8-bit packer.
// Each grant is a 4-beat burst (one packed byte); beats are registered
// once and tagged with their source. A fixed idle gap follows every burst
// so the packer's beat counter realigns between bytes.
module din_burst_arbiter #(
  parameter int IDLE_GAP = 1
) (
  input logic                  clk,
  input logic                  rstn,
  din_burst_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  // Last GAP count value before returning to IDLE; unused when IDLE_GAP is 0.
  localparam logic [3:0] GAP_LAST = (IDLE_GAP > 0) ? 4'(IDLE_GAP - 1) : 4'd0;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] beat_cnt;
  logic [3:0] gap_cnt;
  // Owner of the current/most recent burst; doubles as the round-robin pointer.
  logic       last_owner;
  logic       pick;

  logic [1:0] dout_p1;
  logic       dout_en_p1;
  logic       dout_src_p1;

  // Round-robin choice and next-state decode.
  always_comb begin
    state_nxt = state;
    pick      = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick = ~last_owner;
    end else begin
      pick = bus.req1;
    end
    case (state)
      IDLE: begin
        if (bus.arb_en && (bus.req0 || bus.req1)) begin
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (beat_cnt == 2'd3) begin
          state_nxt = (IDLE_GAP > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      beat_cnt   <= 2'd0;
      gap_cnt    <= 4'd0;
      last_owner <= 1'b1;
    end else begin
      state    <= state_nxt;
      beat_cnt <= (state == BURST) ? beat_cnt + 2'd1 : 2'd0;
      gap_cnt  <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (state == IDLE && state_nxt == BURST) begin
        last_owner <= pick;
      end
    end
  end

  // Stage p1: register the granted requester's beat toward the packer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout_p1     <= 2'd0;
      dout_en_p1  <= 1'b0;
      dout_src_p1 <= 1'b0;
    end else begin
      dout_en_p1 <= (state == BURST);
      if (state == BURST) begin
        dout_p1     <= last_owner ? bus.din1 : bus.din0;
        dout_src_p1 <= last_owner;
      end
    end
  end

  assign bus.gnt0     = (state == BURST) && !last_owner;
  assign bus.gnt1     = (state == BURST) && last_owner;
  assign bus.busy     = (state != IDLE);
  assign bus.dout     = dout_p1;
  assign bus.dout_en  = dout_en_p1;
  assign bus.dout_src = dout_src_p1;

endmodule

// File: tb/tb_din_burst_arbiter.sv
// Directed bench for din_burst_arbiter: three instances with IDLE_GAP of
// 1, 0 and 15, driven from one linear stimulus sequence.
module tb_din_burst_arbiter;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  din_burst_arbiter_if b1();
  din_burst_arbiter_if b0();
  din_burst_arbiter_if b15();

  din_burst_arbiter #(.IDLE_GAP(1))  u1  (.clk(clk), .rstn(rstn), .bus(b1));
  din_burst_arbiter #(.IDLE_GAP(0))  u0  (.clk(clk), .rstn(rstn), .bus(b0));
  din_burst_arbiter #(.IDLE_GAP(15)) u15 (.clk(clk), .rstn(rstn), .bus(b15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds both requests and checks window owner, length, spacing and data.
  task automatic observe(input int which, input int ncyc, input string tag,
                         input int exp_gap, input int exp_wins);
    logic [1:0] g;
    logic [1:0] prev_g;
    logic [1:0] d;
    logic       e;
    logic       s;
    int         wins;
    int         len;
    int         idle;
    logic       exp_o;
    prev_g = 2'b00;
    wins = 0;
    len = 0;
    idle = 0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      case (which)
        0:       begin g = {b0.gnt1, b0.gnt0};   d = b0.dout;  e = b0.dout_en;  s = b0.dout_src;  end
        15:      begin g = {b15.gnt1, b15.gnt0}; d = b15.dout; e = b15.dout_en; s = b15.dout_src; end
        default: begin g = {b1.gnt1, b1.gnt0};   d = b1.dout;  e = b1.dout_en;  s = b1.dout_src;  end
      endcase
      chk({tag, "_both_gnt"}, 32'(g == 2'b11), 32'd0);
      if (e) chk({tag, "_data"}, 32'(d), s ? 32'd2 : 32'd1);
      if (g != 2'b00) begin
        if (prev_g == 2'b00) begin
          if (wins > 0) chk({tag, "_spacing"}, 32'(idle), 32'(exp_gap));
          exp_o = wins[0];
          chk({tag, "_owner"}, 32'(g[1]), 32'(exp_o));
          wins++;
          len = 1;
        end else begin
          len++;
        end
      end else begin
        if (prev_g != 2'b00) begin
          chk({tag, "_len"}, 32'(len), 32'd4);
          idle = 1;
        end else begin
          idle++;
        end
      end
      prev_g = g;
    end
    chk({tag, "_wins"}, 32'(wins), 32'(exp_wins));
  endtask

  initial begin
    logic [7:0] pbyte;
    int         ng;
    int         ne;
    total = 0;
    bad = 0;
    pbyte = 8'd0;
    rstn = 1'b0;
    b1.arb_en = 1'b1;  b1.req0 = 1'b0;  b1.req1 = 1'b0;  b1.din0 = 2'd0;  b1.din1 = 2'd0;
    b0.arb_en = 1'b1;  b0.req0 = 1'b0;  b0.req1 = 1'b0;  b0.din0 = 2'd1;  b0.din1 = 2'd2;
    b15.arb_en = 1'b1; b15.req0 = 1'b0; b15.req1 = 1'b0; b15.din0 = 2'd1; b15.din1 = 2'd2;

    // Reset state
    repeat (3) step();
    chk("rst_gnt0", 32'(b1.gnt0), 32'd0);
    chk("rst_gnt1", 32'(b1.gnt1), 32'd0);
    chk("rst_dout", 32'(b1.dout), 32'd0);
    chk("rst_dout_en", 32'(b1.dout_en), 32'd0);
    chk("rst_dout_src", 32'(b1.dout_src), 32'd0);
    chk("rst_busy", 32'(b1.busy), 32'd0);
    rstn = 1'b1;
    step();

    // Single request: beats 3,2,1,0 pack to 0xE4
    b1.req0 = 1'b1;
    b1.din0 = 2'd3;
    step();
    b1.req0 = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      chk("single_gnt0", 32'(b1.gnt0), (c < 4) ? 32'd1 : 32'd0);
      chk("single_gnt1", 32'(b1.gnt1), 32'd0);
      chk("single_busy", 32'(b1.busy), 32'd1);
      if (c > 0) begin
        chk("single_dout_en", 32'(b1.dout_en), 32'd1);
        chk("single_dout", 32'(b1.dout), 32'(4 - c));
        chk("single_src", 32'(b1.dout_src), 32'd0);
        pbyte = {pbyte[5:0], b1.dout};
      end else begin
        chk("single_dout_en0", 32'(b1.dout_en), 32'd0);
      end
      if (c < 4) b1.din0 = 2'(3 - c);
      step();
    end
    chk("single_byte", 32'(pbyte), 32'hE4);
    chk("single_end_en", 32'(b1.dout_en), 32'd0);
    chk("single_end_busy", 32'(b1.busy), 32'd0);
    chk("single_hold_dout", 32'(b1.dout), 32'd0);

    // Contention with IDLE_GAP=1: order 0,1,0,1, 2-cycle spacing
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    b1.din0 = 2'd1;
    b1.din1 = 2'd2;
    b1.req0 = 1'b1;
    b1.req1 = 1'b1;
    observe(1, 24, "cont", 2, 4);
    b1.req0 = 1'b0;
    b1.req1 = 1'b0;
    step();
    chk("cont_idle", 32'(b1.busy), 32'd0);

    // Burst immunity: req1 dropped after beat 1, req0 raised
    b1.req1 = 1'b1;
    step();
    chk("imm_gnt1_b0", 32'(b1.gnt1), 32'd1);
    step();
    chk("imm_gnt1_b1", 32'(b1.gnt1), 32'd1);
    b1.req1 = 1'b0;
    b1.req0 = 1'b1;
    step();
    chk("imm_gnt1_b2", 32'(b1.gnt1), 32'd1);
    chk("imm_gnt0_b2", 32'(b1.gnt0), 32'd0);
    chk("imm_src", 32'(b1.dout_src), 32'd1);
    step();
    chk("imm_gnt1_b3", 32'(b1.gnt1), 32'd1);
    step();
    chk("imm_gap_gnt1", 32'(b1.gnt1), 32'd0);
    chk("imm_gap_gnt0", 32'(b1.gnt0), 32'd0);
    step();
    chk("imm_idle_gnt0", 32'(b1.gnt0), 32'd0);
    step();
    chk("imm_next_gnt0", 32'(b1.gnt0), 32'd1);
    b1.req0 = 1'b0;
    repeat (5) step();

    // arb_en gating
    b1.arb_en = 1'b0;
    b1.req0 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("gate_no_gnt", 32'(b1.gnt0 | b1.gnt1 | b1.busy), 32'd0);
    end
    b1.arb_en = 1'b1;
    step();
    chk("gate_gnt0", 32'(b1.gnt0), 32'd1);
    b1.arb_en = 1'b0;
    b1.req0 = 1'b0;
    ng = 1;
    ne = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (b1.gnt0) ng++;
      if (b1.dout_en) ne++;
    end
    chk("gate_gnt_len", 32'(ng), 32'd4);
    chk("gate_beats", 32'(ne), 32'd4);
    b1.arb_en = 1'b1;

    // Reset on beat 2 of a req1 burst
    b1.req1 = 1'b1;
    step();
    chk("rmid_gnt1", 32'(b1.gnt1), 32'd1);
    b1.req1 = 1'b0;
    step();
    step();
    chk("rmid_pre_en", 32'(b1.dout_en), 32'd1);
    rstn = 1'b0;
    step();
    chk("rmid_gnt0", 32'(b1.gnt0), 32'd0);
    chk("rmid_gnt1_0", 32'(b1.gnt1), 32'd0);
    chk("rmid_dout", 32'(b1.dout), 32'd0);
    chk("rmid_dout_en", 32'(b1.dout_en), 32'd0);
    chk("rmid_src", 32'(b1.dout_src), 32'd0);
    chk("rmid_busy", 32'(b1.busy), 32'd0);
    rstn = 1'b1;
    b1.req0 = 1'b1;
    b1.req1 = 1'b1;
    step();
    chk("rmid_next_gnt0", 32'(b1.gnt0), 32'd1);
    chk("rmid_next_gnt1", 32'(b1.gnt1), 32'd0);
    b1.req0 = 1'b0;
    b1.req1 = 1'b0;
    repeat (6) step();

    // IDLE_GAP=0: windows 1 cycle apart
    b0.req0 = 1'b1;
    b0.req1 = 1'b1;
    observe(0, 15, "gap0", 1, 3);
    b0.req0 = 1'b0;
    b0.req1 = 1'b0;

    // IDLE_GAP=15: windows 16 cycles apart
    b15.req0 = 1'b1;
    b15.req1 = 1'b1;
    observe(15, 45, "gap15", 16, 3);
    b15.req0 = 1'b0;
    b15.req1 = 1'b0;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
